// File: rtl/shiftreg_pkg.sv
// Shared constants for the 74hc595 pattern sequencer and the driver bench.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: mode encodings for i_mode, FSM state encoding, and a helper
// that sizes the period counter.
package shiftreg_pkg;

  // Pattern advance modes, sampled by the sequencer in its NEXT state.
  localparam logic [1:0] MODE_TOGGLE = 2'd0;
  localparam logic [1:0] MODE_WALK   = 2'd1;
  localparam logic [1:0] MODE_COUNT  = 2'd2;
  localparam logic [1:0] MODE_LFSR   = 2'd3;

  // State encoding. Kept as plain localparams so other benches can decode
  // a probed state bus without pulling in the enum type.
  localparam logic [2:0] ST_SEND_ENC      = 3'd0;
  localparam logic [2:0] ST_GAP_ENC       = 3'd1;
  localparam logic [2:0] ST_WAIT_RDY_ENC  = 3'd2;
  localparam logic [2:0] ST_WAIT_TICK_ENC = 3'd3;
  localparam logic [2:0] ST_NEXT_ENC      = 3'd4;

  typedef enum logic [2:0] {
    ST_SEND      = ST_SEND_ENC,
    ST_GAP       = ST_GAP_ENC,
    ST_WAIT_RDY  = ST_WAIT_RDY_ENC,
    ST_WAIT_TICK = ST_WAIT_TICK_ENC,
    ST_NEXT      = ST_NEXT_ENC
  } state_t;

  // Period counter width: max(1, clog2(period)). A period of 1 or 2 still
  // needs one bit so the counter and its compare remain well formed.
  function automatic int unsigned cnt_width(input int unsigned period);
    int unsigned w;
    w = $clog2(period);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/shiftreg_pattern_next.sv
// Next-word function for the pattern sequencer (toggle/walk/count/LFSR).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
//
// Ports:
//   d    in  WIDTH  current word
//   mode in  2      advance mode (MODE_TOGGLE..MODE_LFSR)
//   taps in  WIDTH  LFSR feedback mask
//   nxt  out WIDTH  advanced word
module shiftreg_pattern_next
  import shiftreg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] taps,
  output logic [WIDTH-1:0] nxt
);

  logic w_is_zero;
  logic w_fb;

  assign w_is_zero = (d == '0);
  // Feedback bit is the parity of the tapped bits.
  assign w_fb      = ^(d & taps);

  always_comb begin
    nxt = d;
    case (mode)
      MODE_TOGGLE: nxt = ~d;
      // An all-zero word would rotate forever as zero; restart at bit 0.
      MODE_WALK:   nxt = w_is_zero ? WIDTH'(1) : {d[WIDTH-2:0], d[WIDTH-1]};
      MODE_COUNT:  nxt = d + WIDTH'(1);
      // All-zero is the LFSR lock-up state; escape to 1.
      MODE_LFSR:   nxt = w_is_zero ? WIDTH'(1) : {d[WIDTH-2:0], w_fb};
      default:     nxt = d;
    endcase
  end

endmodule

// File: rtl/shiftreg_pattern_gen.sv
// Pattern sequencer: strobes a WIDTH-bit word into the 595 driver, waits for
// ready, holds PERIOD cycles, then advances the word by the selected mode.
// Latency: PERIOD+4 cycles between o_enable pulses with i_ready already high.
// Backpressure: stalls in WAIT_RDY until i_ready; i_hold freezes the period.
//
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_ready              driver idle/done
//   i_mode               advance mode, only sampled in NEXT
//   i_hold               freezes the period counter while high
//   i_load, i_load_data  direct load, only accepted in WAIT_TICK
//   o_data               word presented to the driver
//   o_enable             one-cycle send strobe
//   o_busy               high in every state except WAIT_TICK
//   o_frames             frames advanced, wraps
module shiftreg_pattern_gen
  import shiftreg_pkg::*;
#(
  parameter int unsigned     WIDTH   = 8,
  parameter int unsigned     PERIOD  = 25_000_000,
  parameter logic [WIDTH-1:0] INIT   = 'h55,
  parameter logic [WIDTH-1:0] TAPS   = 'hB8,
  parameter int unsigned     FRAME_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ready,
  input  logic [1:0]         i_mode,
  input  logic               i_hold,
  input  logic               i_load,
  input  logic [WIDTH-1:0]   i_load_data,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_enable,
  output logic               o_busy,
  output logic [FRAME_W-1:0] o_frames
);

  localparam int unsigned    CNT_W    = cnt_width(PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   w_data_nxt;
  logic               r_enable;
  logic               w_enable_nxt;
  logic [FRAME_W-1:0] r_frames;
  logic [FRAME_W-1:0] w_frames_nxt;
  logic [WIDTH-1:0]   w_adv;

  shiftreg_pattern_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .d    (r_data),
    .mode (i_mode),
    .taps (TAPS),
    .nxt  (w_adv)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_SEND;
      r_cnt    <= '0;
      r_data   <= INIT;
      r_enable <= 1'b0;
      r_frames <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_data   <= w_data_nxt;
      r_enable <= w_enable_nxt;
      r_frames <= w_frames_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_data_nxt   = r_data;
    // Strobe is only ever set on the SEND edge, so it drops on the next one.
    w_enable_nxt = 1'b0;
    w_frames_nxt = r_frames;

    case (r_state)
      ST_SEND: begin
        w_enable_nxt = 1'b1;
        w_state_nxt  = ST_GAP;
      end

      // One spare cycle so the driver can drop ready before we sample it.
      ST_GAP: begin
        w_state_nxt = ST_WAIT_RDY;
      end

      ST_WAIT_RDY: begin
        if (i_ready) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_WAIT_TICK;
        end
      end

      ST_WAIT_TICK: begin
        // Load beats both hold and terminal count: no advance on that frame.
        if (i_load) begin
          w_data_nxt  = i_load_data;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SEND;
        end else if (!i_hold) begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_NEXT;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end

      ST_NEXT: begin
        w_data_nxt   = w_adv;
        w_frames_nxt = r_frames + FRAME_W'(1);
        w_state_nxt  = ST_SEND;
      end

      default: begin
        w_state_nxt = ST_SEND;
      end
    endcase
  end

  assign o_data   = r_data;
  assign o_enable = r_enable;
  assign o_busy   = (r_state != ST_WAIT_TICK);
  assign o_frames = r_frames;

  // The strobe must never stretch across two cycles.
  a_enable_single : assert property (
    @(posedge i_clk) disable iff (i_rst) r_enable |=> !r_enable
  );

  // The word only moves on the NEXT edge or an accepted load; the driver
  // never sees it change mid-shift.
  a_data_stable : assert property (
    @(posedge i_clk) disable iff (i_rst)
      ((r_state != ST_NEXT) && !((r_state == ST_WAIT_TICK) && i_load))
        |=> $stable(r_data)
  );

endmodule

// File: tb/tb_shiftreg_pattern_gen.sv
module tb_shiftreg_pattern_gen;

  localparam int W         = 8;
  localparam int PERIOD    = 4;
  localparam int DRV_BUSY  = 8;
  // Enable-to-enable spacing with the driver model below and no hold:
  // SEND + GAP + WAIT_RDY (1 + DRV_BUSY) + PERIOD + NEXT.
  localparam int FRAME_CYC = PERIOD + 4 + DRV_BUSY;
  localparam logic [W-1:0] INIT_V = 8'h55;
  localparam int TAPS_V    = 'hB8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ready;
  logic [1:0]    mode;
  logic          hold;
  logic          load;
  logic [W-1:0]  load_data;
  logic [W-1:0]  data;
  logic          en;
  logic          busy;
  logic [15:0]   frames;

  always #5 clk = ~clk;

  shiftreg_pattern_gen #(
    .WIDTH   (W),
    .PERIOD  (PERIOD),
    .INIT    (INIT_V),
    .TAPS    (8'hB8),
    .FRAME_W (16)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ready     (ready),
    .i_mode      (mode),
    .i_hold      (hold),
    .i_load      (load),
    .i_load_data (load_data),
    .o_data      (data),
    .o_enable    (en),
    .o_busy      (busy),
    .o_frames    (frames)
  );

  // Driver model: ready drops for DRV_BUSY cycles after each enable it sees.
  int drv_cnt = 0;
  always @(posedge clk) begin
    if (en) drv_cnt <= DRV_BUSY;
    else if (drv_cnt > 0) drv_cnt <= drv_cnt - 1;
  end
  assign ready = (drv_cnt == 0);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   dbl = 0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (prev_en && en) dbl = dbl + 1;
    prev_en = en;
  end

  int n_pass = 0;
  int n_chk  = 0;

  int          last_stamp;
  logic [W-1:0] exp_data;
  int          exp_frames;

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] start;
    logic [W-1:0] exp1;
    logic [W-1:0] exp2;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference next-word, from the mode rules with plain integer arithmetic.
  function automatic logic [W-1:0] ref_next(input logic [W-1:0] d, input int m);
    int v;
    v = int'(d);
    case (m)
      0: return W'(255 - v);
      1: return (v == 0) ? W'(1) : W'(((v * 2) % 256) + (v / 128));
      2: return W'((v + 1) % 256);
      default: return (v == 0) ? W'(1) :
                      W'(((v * 2) % 256) + ($countones(v & TAPS_V) % 2));
    endcase
  endfunction

  task automatic wait_enable(output int stamp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n = n + 1;
    end while (!en && n < 200);
    check("enable_seen", 32'(en), 32'd1);
    stamp = cyc;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n = n + 1;
    end while (busy && n < 100);
    check("reach_wait_tick", 32'(busy), 32'd0);
  endtask

  task automatic frame_check(input string tag, input int exp_interval);
    int st;
    wait_enable(st);
    check({tag, "_data"}, 32'(data), 32'(exp_data));
    check({tag, "_frames"}, 32'(frames), 32'(exp_frames[15:0]));
    check({tag, "_interval"}, 32'(st - last_stamp), 32'(exp_interval));
    last_stamp = st;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int h;
    int m;
    logic [W-1:0] ld;

    vecs[0] = '{2'd1, 8'h80, 8'h01, 8'h02};
    vecs[1] = '{2'd1, 8'h00, 8'h01, 8'h02};
    vecs[2] = '{2'd2, 8'hFE, 8'hFF, 8'h00};
    vecs[3] = '{2'd3, 8'h80, 8'h01, 8'h02};
    vecs[4] = '{2'd3, 8'h00, 8'h01, 8'h02};
    vecs[5] = '{2'd0, 8'h3C, 8'hC3, 8'h3C};

    rst = 1'b1; mode = 2'd0; hold = 1'b0; load = 1'b0; load_data = '0;
    repeat (3) @(negedge clk);
    check("rst_data",   32'(data),   32'h55);
    check("rst_enable", 32'(en),     32'd0);
    check("rst_busy",   32'(busy),   32'd1);
    check("rst_frames", 32'(frames), 32'd0);

    // First edge after release must strobe.
    rst = 1'b0;
    @(negedge clk);
    check("first_enable", 32'(en), 32'd1);
    check("first_data",   32'(data), 32'h55);
    last_stamp = cyc;
    exp_data   = INIT_V;
    exp_frames = 0;
    @(negedge clk);
    check("enable_drop", 32'(en), 32'd0);

    // Mode 0 toggling from INIT.
    for (int i = 0; i < 2; i++) begin
      exp_data   = ref_next(exp_data, 0);
      exp_frames = exp_frames + 1;
      frame_check("toggle", FRAME_CYC);
    end

    // Table: load a start word, then two advances in the given mode.
    for (int i = 0; i < 6; i++) begin
      mode = vecs[i].mode;
      wait_idle();
      load = 1'b1; load_data = vecs[i].start;
      @(negedge clk);
      load = 1'b0;
      exp_data = vecs[i].start;
      frame_check("tbl_load", FRAME_CYC - PERIOD);
      exp_data = vecs[i].exp1; exp_frames = exp_frames + 1;
      frame_check("tbl_adv1", FRAME_CYC);
      exp_data = vecs[i].exp2; exp_frames = exp_frames + 1;
      frame_check("tbl_adv2", FRAME_CYC);
    end

    // Hold for 10 cycles in WAIT_TICK stretches the frame by exactly 10.
    mode = 2'd2;
    wait_idle();
    hold = 1'b1;
    repeat (10) @(negedge clk);
    hold = 1'b0;
    exp_data = ref_next(exp_data, 2); exp_frames = exp_frames + 1;
    frame_check("hold10", FRAME_CYC + 10);

    // Load and mode changes while waiting for ready are ignored.
    repeat (2) @(negedge clk);
    check("busy_wait_rdy", 32'(busy), 32'd1);
    load = 1'b1; load_data = 8'h99; mode = 2'd0;
    repeat (3) @(negedge clk);
    load = 1'b0; mode = 2'd2;
    exp_data = ref_next(exp_data, 2); exp_frames = exp_frames + 1;
    frame_check("rdy_load_ignored", FRAME_CYC);

    // Load landing on the terminal-count edge wins; no advance.
    wait_idle();
    repeat (PERIOD - 1) @(negedge clk);
    load = 1'b1; load_data = 8'h3C;
    @(negedge clk);
    load = 1'b0;
    exp_data = 8'h3C;
    frame_check("tc_load", FRAME_CYC - 1);

    // Randomized frames against the reference model.
    for (int it = 0; it < 40; it++) begin
      m = int'($urandom_range(0, 3));
      mode = 2'(m);
      if ($urandom_range(0, 3) == 0) begin
        k  = int'($urandom_range(0, PERIOD - 1));
        ld = W'($urandom);
        wait_idle();
        for (int j = 0; j < k; j++) begin
          hold = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        hold = 1'($urandom_range(0, 1));
        load = 1'b1; load_data = ld;
        @(negedge clk);
        load = 1'b0; hold = 1'b0;
        exp_data = ld;
        frame_check("rnd_load", FRAME_CYC - PERIOD + k);
      end else begin
        h = int'($urandom_range(0, 5));
        wait_idle();
        hold = (h != 0);
        repeat (h) @(negedge clk);
        hold = 1'b0;
        exp_data = ref_next(exp_data, m); exp_frames = exp_frames + 1;
        frame_check("rnd_adv", FRAME_CYC + h);
      end
    end

    // Reset during GAP: outputs return asynchronously.
    check("in_gap_enable", 32'(en), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_data",   32'(data),   32'h55);
    check("arst_enable", 32'(en),     32'd0);
    check("arst_busy",   32'(busy),   32'd1);
    check("arst_frames", 32'(frames), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_enable", 32'(en), 32'd1);
    check("post_rst_data",   32'(data), 32'h55);

    check("enable_double_pulse", 32'(dbl), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shiftreg_pattern_gen.md
# shiftreg_pattern_gen

Parametrised pattern sequencer that feeds the 74hc595 shift-register driver. It holds a WIDTH-bit word and strobes it into the driver, then waits for the driver's ready. After a programmable hold period it advances the word according to a selectable mode: toggle, walking one, binary count or LFSR. It sits between system control (mode, hold, direct load) and the shift driver's data/enable/ready handshake, and provides frame counting for status.

## Interface
- WIDTH, 8: pattern and driver word width (≥ 2)
- PERIOD, 25_000_000: clock cycles in WAIT_TICK per frame (≥ 1)
- INIT, 'h55: reset value of o_data (WIDTH bits)
- TAPS, 'hB8: LFSR feedback mask (WIDTH bits)
- FRAME_W, 16: frame counter width

- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_ready  in  1  driver idle/done
- i_mode  in  2  0 toggle, 1 walk, 2 count, 3 LFSR; sampled in NEXT
- i_hold  in  1  freezes period counter while high
- i_load  in  1  load request, accepted only in WAIT_TICK
- i_load_data  in  WIDTH  value for load
- o_data  out  WIDTH  word presented to driver
- o_enable  out  1  one-cycle send strobe
- o_busy  out  1  high in every state except WAIT_TICK
- o_frames  out  FRAME_W  frames sent, wraps

## Operation
- States: SEND → GAP → WAIT_RDY → WAIT_TICK → NEXT → SEND.
- SEND: o_enable<=1, go GAP.
- GAP: o_enable<=0, go WAIT_RDY. This gives the driver one cycle to drop ready.
- WAIT_RDY: stay until i_ready sampled 1. Then clear period counter and go WAIT_TICK.
- WAIT_TICK: counter increments each cycle unless i_hold. When counter == PERIOD-1 and !i_hold, go NEXT.
- NEXT: o_data<=next(o_data, i_mode), o_frames<=o_frames+1, go SEND.
- next() rules:
  - toggle: ~d
  - walk: rotate left by 1; d==0 → 1
  - count: d+1 mod 2^WIDTH
  - LFSR: {d[WIDTH-2:0], ^(d & TAPS)}; d==0 → 1 (lock-up escape)
- Load: i_load in WAIT_TICK → o_data<=i_load_data, counter cleared, go SEND. o_frames unchanged. i_load is ignored in all other states, and i_hold does not block it.
- i_mode changes outside NEXT have no effect.
- Reset mid-frame: all state is abandoned immediately and reset values apply. There is no partial-frame recovery.

## Timing
- Reset values: o_data=INIT, o_enable=0, o_busy=1, o_frames=0, state=SEND, counter=0.
- First clock edge after reset release: o_enable=1. The next edge returns it to 0. o_enable is never high for 2 consecutive cycles.
- All outputs are registered. o_busy is decoded from the state register.
- Minimum frame, with i_ready already high and no hold: 1 (SEND) + 1 (GAP) + 1 (WAIT_RDY) + PERIOD (WAIT_TICK) + 1 (NEXT) = PERIOD+4 cycles between o_enable pulses.
- o_data is stable from SEND until the NEXT edge. It never changes while the driver is shifting.
- Simultaneous terminal count and i_load in WAIT_TICK: the load wins and no advance occurs.
- PERIOD=1: WAIT_TICK lasts exactly 1 cycle.
- Counter width is max(1, $clog2(PERIOD)). PERIOD must fit.

## Structure
- Shared package shiftreg_pkg: mode constants (MODE_TOGGLE..MODE_LFSR) and state encoding localparams. The package is shared with the driver's bench.
- One sub-module, shiftreg_pattern_next: purely combinational next-word function, ports d, mode, taps → nxt. It is unit-testable alone.
- The top module holds the FSM, period counter, data and frame registers.

## Test plan
All scenarios use WIDTH=8, PERIOD=4, and a driver model that drops ready for 8 cycles after each enable.
- Reset, mode 0: o_enable pulses (1 cycle each). o_data sequence 0x55, 0xAA, 0x55. o_frames counts 1, 2.
- Mode 1 from load 0x80 → 0x01, 0x02. Load 0x00 → next 0x01.
- Mode 2 from load 0xFE → 0xFF, 0x00 (wrap). Mode 3 from 0x80 → 0x01, and from 0x00 → 0x01.
- i_hold high for 10 cycles in WAIT_TICK: enable gap extends by exactly 10 cycles. i_load during WAIT_RDY is ignored, and o_busy=1 there.
- i_load=0x3C coinciding with terminal count: next o_enable presents 0x3C and o_frames is unchanged.
- Assert i_rst during GAP: outputs asynchronously return to INIT/0/1/0. The first enable comes one edge after release.
